mjpg_marker_parser: RTL
=======================

MJPG_MARKER_PARSER -- requirements
Module: mjpg_marker_parser

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, entropy-byte FIFO depth (power of 2, >=4).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 jvalid  input  1  input byte strobe; no backpressure toward the source.
REQ-005 jpeg  input  8  MJPG byte stream (stuffed, with markers).
REQ-006 evalid / eready / edata[8] / elast  out/in/out/out  unstuffed entropy byte stream; elast marks the final byte before EOI.
REQ-007 frame_start  output  1  one-cycle pulse when SOI is accepted.
REQ-008 frame_end  output  1  one-cycle pulse when EOI is accepted.
REQ-009 width / height  output  12 each  SOF0 dimensions; dims_valid output 1 is high once both are captured for the current frame.
REQ-010 err_overflow / err_marker  output  1 each  sticky error flags; cleared only by rst.

Function
REQ-011 FSM states: IDLE, MARK, LEN_HI, LEN_LO, SEG, ENTROPY, ENT_FF. Bytes advance state only when jvalid=1.
REQ-012 IDLE: FF then D8 -> frame_start, MARK; any other byte is discarded silently.
REQ-013 MARK: skip FF fill bytes; D8 re-arms the frame (frame_start again); any other marker code -> LEN_HI.
REQ-014 LEN_HI/LEN_LO: capture 16-bit L; SEG consumes L-2 bytes; L<2 -> err_marker, IDLE.
REQ-015 SOF0 (C0): payload byte 1-2 -> height, bytes 3-4 -> width (low 12 bits); dims_valid is set after width LSB.
REQ-016 SOS (DA): at end of segment -> ENTROPY; other segments -> MARK (expect FF).
REQ-017 A byte other than FF in MARK while expecting a marker -> err_marker, IDLE.
REQ-018 ENTROPY: non-FF byte -> data; FF -> ENT_FF.
REQ-019 ENT_FF: 00 -> data byte FF; D0-D7 -> dropped, ENTROPY; FF -> stay in ENT_FF; D9 -> EOI; D8 -> err_marker, frame_start, MARK; other codes -> err_marker, IDLE.
REQ-020 Data bytes pass through a 1-byte staging register; the staged byte is pushed with elast=0 when the next data byte arrives, or with elast=1 on EOI.
REQ-021 EOI: frame_end pulses in the cycle after D9 is accepted; dims_valid clears; next state is IDLE.
REQ-022 An EOI with an empty staging register pushes nothing and still pulses frame_end.
REQ-023 Output: evalid = FIFO not empty; edata/elast = FIFO head; a pop occurs on evalid&eready.
REQ-024 A push and a pop in the same cycle on a full FIFO both succeed.
REQ-025 A push into a full FIFO with no pop drops the byte and sets err_overflow.
REQ-026 Worst-case latency from the input byte to evalid is 2 cycles after the following data byte (or after EOI).
REQ-027 Width/height hold their last values until the next SOF0.

Reset
REQ-028 Reset state: FSM in IDLE, FIFO and staging register empty, and all outputs 0 (evalid, elast, frame_start, frame_end, width, height, dims_valid, err_*).
REQ-029 Reset mid-frame discards all buffered bytes; no frame_end is generated.

Configuration
REQ-030 MJPG_PARSER_STATS_EN is the only build macro.
REQ-031 With MJPG_PARSER_STATS_EN defined: add outputs frame_cnt[16] (increments on frame_end, wraps) and rst_marker_cnt[16] (counts D0-D7).
REQ-032 Without MJPG_PARSER_STATS_EN: those ports and counters are absent, and all other behaviour is identical.

Structure
REQ-033 Shared package mjpg_pkg holds the marker codes (SOI, EOI, SOF0, SOS, RST0-7, STUFF) and the FSM state enum.
REQ-034 One sub-module, mjpg_byte_fifo: 9-bit wide {elast, byte}, FIFO_DEPTH deep, with push/pop/full/empty.

Verification
REQ-035 FF D8, then FF C0 00 11 08 00 F0 01 40 03 ..., then FF DA, then entropy 12 FF 00 34, then FF D9 -> frame_start; height=240, width=320, dims_valid=1; output 12, FF, 34 with elast on 34; frame_end.
REQ-036 Entropy 56 FF D3 78 FF FF D9 -> output 56, 78 (elast); RST dropped; fill byte FF tolerated.
REQ-037 eready=0 while 20 entropy bytes stream at FIFO_DEPTH=16 -> err_overflow=1; 16 bytes are retained in order.
REQ-038 FF D8 in ENTROPY without EOI -> err_marker=1, frame_start pulse, parsing continues with the new header.
REQ-039 Assert rst while bytes are buffered in ENTROPY -> evalid=0 the next cycle; SOI restarts cleanly.
REQ-040 Back-to-back frames with eready toggled randomly -> byte-exact match to the reference unstuffed streams, and frame_cnt=N when the stats macro is defined.

Source files
------------

// File: rtl/mjpg_pkg.sv
// Marker codes and parser state encoding shared by the MJPG marker parser files.
package mjpg_pkg;

  localparam logic [7:0] MK_PREFIX = 8'hFF;
  localparam logic [7:0] MK_STUFF  = 8'h00;
  localparam logic [7:0] MK_SOI    = 8'hD8;
  localparam logic [7:0] MK_EOI    = 8'hD9;
  localparam logic [7:0] MK_SOF0   = 8'hC0;
  localparam logic [7:0] MK_SOS    = 8'hDA;
  localparam logic [7:0] MK_RST0   = 8'hD0;
  localparam logic [7:0] MK_RST7   = 8'hD7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_SEG,
    ST_ENTROPY,
    ST_ENT_FF
  } state_e;

  function automatic logic is_rst_marker(input logic [7:0] b);
    return (b >= MK_RST0) && (b <= MK_RST7);
  endfunction

endpackage

// File: rtl/mjpg_byte_fifo.sv
// Entropy byte FIFO, {elast, byte} wide; a push into a full FIFO lands only if a pop frees a slot.
module mjpg_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [8:0] wdata_i,
  input  logic       pop_i,
  output logic [8:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wr_en   = push_i & (~full_o | pop_i);
  assign rd_en   = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PTR_ONE;
      if (rd_en) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mjpg_marker_parser.sv
// MJPG marker parser: frame events, SOF0 dimensions and an unstuffed entropy byte stream.
// Build macro MJPG_PARSER_STATS_EN adds frame_cnt and rst_marker_cnt outputs.
module mjpg_marker_parser
  import mjpg_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MJPG_PARSER_STATS_EN
  output logic [15:0] frame_cnt,
  output logic [15:0] rst_marker_cnt,
`endif
  input  logic        jvalid,
  input  logic [7:0]  jpeg,
  output logic        evalid,
  input  logic        eready,
  output logic [7:0]  edata,
  output logic        elast,
  output logic        frame_start,
  output logic        frame_end,
  output logic [11:0] width,
  output logic [11:0] height,
  output logic        dims_valid,
  output logic        err_overflow,
  output logic        err_marker
);

  state_e      state_q, state_d;
  logic        ff_q, ff_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] rem_q, rem_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  stg_q, stg_d;
  logic        stg_vld_q, stg_vld_d;
  logic [11:0] width_q, width_d, height_q, height_d;
  logic        dims_q, dims_d, fs_q, fs_d, fe_q, fe_d;
  logic        eovf_q, eovf_d, emk_q, emk_d;
  logic        data_en, seg_end, push, pop, full, empty;
  logic [8:0]  push_data, head;
  logic [15:0] len;

  always_comb begin
    state_d   = state_q;
    ff_d      = ff_q;
    code_d    = code_q;
    len_hi_d  = len_hi_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    stg_d     = stg_q;
    stg_vld_d = stg_vld_q;
    width_d   = width_q;
    height_d  = height_q;
    dims_d    = dims_q;
    fs_d      = 1'b0;
    fe_d      = 1'b0;
    emk_d     = emk_q;
    data_en   = 1'b0;
    seg_end   = 1'b0;
    push      = 1'b0;
    push_data = {1'b0, stg_q};
    len       = {len_hi_q, jpeg};
    if (jvalid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ff_q && jpeg == MK_SOI) begin
            fs_d = 1'b1; dims_d = 1'b0; ff_d = 1'b0; state_d = ST_MARK;
          end else begin
            ff_d = (jpeg == MK_PREFIX);
          end
        end
        // ff_q distinguishes "waiting for FF" from "FF seen, waiting for the code"
        ST_MARK: begin
          if (!ff_q) begin
            if (jpeg == MK_PREFIX) ff_d = 1'b1;
            else begin emk_d = 1'b1; state_d = ST_IDLE; end
          end else if (jpeg == MK_SOI) begin
            fs_d = 1'b1; dims_d = 1'b0; ff_d = 1'b0;
          end else if (jpeg != MK_PREFIX) begin
            code_d = jpeg; ff_d = 1'b0; state_d = ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          len_hi_d = jpeg; state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          rem_d = len - 16'd2;
          idx_d = 3'd0;
          if (len < 16'd2) begin emk_d = 1'b1; ff_d = 1'b0; state_d = ST_IDLE; end
          else if (len == 16'd2) seg_end = 1'b1;
          else state_d = ST_SEG;
        end
        // SOF0 payload index 0 is the sample precision; height and width follow it
        ST_SEG: begin
          if (code_q == MK_SOF0) begin
            case (idx_q)
              3'd1: height_d[11:8] = jpeg[3:0];
              3'd2: height_d[7:0]  = jpeg;
              3'd3: width_d[11:8]  = jpeg[3:0];
              3'd4: begin width_d[7:0] = jpeg; dims_d = 1'b1; end
              default: ;
            endcase
          end
          if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
          rem_d   = rem_q - 16'd1;
          seg_end = (rem_q == 16'd1);
        end
        ST_ENTROPY: begin
          if (jpeg == MK_PREFIX) state_d = ST_ENT_FF;
          else data_en = 1'b1;
        end
        ST_ENT_FF: begin
          state_d = ST_ENTROPY;
          if (jpeg == MK_STUFF) data_en = 1'b1;
          else if (jpeg == MK_PREFIX) state_d = ST_ENT_FF;
          else if (jpeg == MK_EOI) begin
            push = stg_vld_q; push_data = {1'b1, stg_q}; stg_vld_d = 1'b0;
            fe_d = 1'b1; dims_d = 1'b0; ff_d = 1'b0; state_d = ST_IDLE;
          end else if (!is_rst_marker(jpeg)) begin
            // an unterminated frame abandons its staged byte
            emk_d = 1'b1; stg_vld_d = 1'b0; ff_d = 1'b0;
            if (jpeg == MK_SOI) begin fs_d = 1'b1; dims_d = 1'b0; state_d = ST_MARK; end
            else state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (seg_end) begin
      ff_d    = 1'b0;
      state_d = (code_q == MK_SOS) ? ST_ENTROPY : ST_MARK;
    end
    if (data_en) begin
      push      = stg_vld_q;
      push_data = {1'b0, stg_q};
      stg_d     = (state_q == ST_ENT_FF) ? MK_PREFIX : jpeg;
      stg_vld_d = 1'b1;
    end
    eovf_d = eovf_q | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ff_q      <= 1'b0;
      stg_vld_q <= 1'b0;
      width_q   <= '0;
      height_q  <= '0;
      dims_q    <= 1'b0;
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
      eovf_q    <= 1'b0;
      emk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ff_q      <= ff_d;
      stg_vld_q <= stg_vld_d;
      width_q   <= width_d;
      height_q  <= height_d;
      dims_q    <= dims_d;
      fs_q      <= fs_d;
      fe_q      <= fe_d;
      eovf_q    <= eovf_d;
      emk_q     <= emk_d;
    end
    code_q   <= code_d;
    len_hi_q <= len_hi_d;
    rem_q    <= rem_d;
    idx_q    <= idx_d;
    stg_q    <= stg_d;
  end

`ifdef MJPG_PARSER_STATS_EN
  logic [15:0] frame_cnt_q, rst_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      rst_cnt_q   <= '0;
    end else begin
      if (fe_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (jvalid && state_q == ST_ENT_FF && is_rst_marker(jpeg)) rst_cnt_q <= rst_cnt_q + 16'd1;
    end
  end

  assign frame_cnt      = frame_cnt_q;
  assign rst_marker_cnt = rst_cnt_q;
`endif

  mjpg_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pop          = eready & ~empty;
  assign evalid       = ~empty;
  assign edata        = empty ? 8'h00 : head[7:0];
  assign elast        = ~empty & head[8];
  assign frame_start  = fs_q;
  assign frame_end    = fe_q;
  assign width        = width_q;
  assign height       = height_q;
  assign dims_valid   = dims_q;
  assign err_overflow = eovf_q;
  assign err_marker   = emk_q;

endmodule
